// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALUOp encodings and the ID/EX control bundle.
package riscv_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ex_ctrl_t;

  // rs2 is a real source for R-type, branches and stores; I-type/load reuse
  // the rs2 bit field as immediate, so it must not trigger a hazard.
  function automatic logic rs2_used(input logic [1:0] alu_op, input logic mem_write);
    return (alu_op == ALUOP_RTYPE) || (alu_op == ALUOP_BRANCH) || mem_write;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction sitting in ID.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [1:0] id_ALUOp,
  input  logic       id_MemWrite,
  input  logic       ex_valid,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_hit, rs2_hit;

  // rs1 is read by every ALUOp class; rs2 only where it is a real source
  always_comb begin
    rs1_hit  = (ex_rd == id_rs1);
    rs2_hit  = (ex_rd == id_rs2) && rs2_used(id_ALUOp, id_MemWrite);
    load_use = id_valid && ex_valid && ex_MemRead && (ex_rd != 5'd0) &&
               (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// downstream stall hold. Optional bubble counter under ID_EX_PERF_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [1:0]        id_ALUOp,
  input  logic [2:0]        id_Funct3,
  input  logic [6:0]        id_Funct7,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_ALUSrc,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_Branch,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_ALUOp,
  output logic [2:0]        ex_Funct3,
  output logic [6:0]        ex_Funct7,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc,
  output logic              ex_ALUSrc,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_Branch,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       bubble_count,
`endif
  output logic              id_stall
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic              vld_q, vld_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              load_use;
  logic              bubble;

  load_use_detect u_lud (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_ALUOp    (id_ALUOp),
    .id_MemWrite (id_MemWrite),
    .ex_valid    (vld_q),
    .ex_MemRead  (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .load_use    (load_use)
  );

  // Freeze front end on hazard or downstream stall; a flush overrides both
  // because the ID instruction is being killed anyway.
  assign id_stall = !flush && (load_use || ex_stall);

  // Next-state: flush > stall hold > load-use bubble > capture
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    bubble = flush || (!ex_stall && load_use);
    if (bubble) begin
      // All-zero slot: ALUOp 00 makes the ALU do a harmless add
      vld_d  = 1'b0;
      ctrl_d = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc_d   = '0;
    end else if (!ex_stall) begin
      vld_d  = id_valid;
      ctrl_d = '{alu_op: id_ALUOp, funct3: id_Funct3, funct7: id_Funct7,
                 alu_src: id_ALUSrc, mem_read: id_MemRead, mem_write: id_MemWrite,
                 reg_write: id_RegWrite, mem_to_reg: id_MemtoReg, branch: id_Branch};
      rs1_d  = id_rs1;
      rs2_d  = id_rs2;
      rd_d   = id_rd;
      rd1_d  = id_rd1;
      rd2_d  = id_rd2;
      imm_d  = id_imm;
      pc_d   = id_pc;
      if (!id_valid) begin
        // Invalid slots never carry side-effecting controls downstream
        ctrl_d.alu_src    = 1'b0;
        ctrl_d.mem_read   = 1'b0;
        ctrl_d.mem_write  = 1'b0;
        ctrl_d.reg_write  = 1'b0;
        ctrl_d.mem_to_reg = 1'b0;
        ctrl_d.branch     = 1'b0;
      end
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bcnt_q;

  // Saturating count of inserted bubbles (flush or load-use)
  always_ff @(posedge clk) begin
    if (reset)                        bcnt_q <= '0;
    else if (bubble && ~&bcnt_q)      bcnt_q <= bcnt_q + 32'd1;
  end

  assign bubble_count = bcnt_q;
`endif

  assign ex_valid    = vld_q;
  assign ex_ALUOp    = ctrl_q.alu_op;
  assign ex_Funct3   = ctrl_q.funct3;
  assign ex_Funct7   = ctrl_q.funct7;
  assign ex_ALUSrc   = ctrl_q.alu_src;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_Branch   = ctrl_q.branch;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_pc       = pc_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage RISC-V core, with integrated load-use hazard detection. It captures decoded control (`ALUOp`, `Funct3`, `Funct7`, memory and writeback controls), operands, immediate and PC from decode, and presents them to the execute stage one cycle later. The `ALUOp`/`Funct3`/`Funct7` outputs drive the ALU controller directly. The block inserts bubbles on load-use hazards and on branch flushes, and holds its contents on downstream stalls.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width
- `PC_W`, 32, program counter width

Ports (clock and reset):
- `clk`  in  1  core clock
- `reset`  in  1  reset, synchronous to `clk`, active-high

Ports (decode side):
- `id_valid`  in  1  decode holds a valid instruction
- `id_ALUOp`  in  2  00 load/store/JALR, 01 branch, 10 R-type, 11 I-type ALU
- `id_Funct3`  in  3  instr[14:12]
- `id_Funct7`  in  7  instr[31:25]
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices
- `id_rd1`, `id_rd2`, `id_imm`  in  DATA_W each  register-file reads and sign-extended immediate
- `id_pc`  in  PC_W  instruction PC
- `id_ALUSrc`, `id_MemRead`, `id_MemWrite`, `id_RegWrite`, `id_MemtoReg`, `id_Branch`  in  1 each  decoded controls

Ports (control):
- `flush`  in  1  taken branch/jump resolved in EX; kill the instruction entering ID/EX
- `ex_stall`  in  1  downstream cannot accept; hold ID/EX

Ports (outputs):
- `ex_valid`  out  1  ID/EX holds a real instruction
- `ex_*`  out  registered copies of every `id_*` field above (same widths)
- `id_stall`  out  1  freeze PC and IF/ID this cycle
- `bubble_count`  out  32  only with `ID_EX_PERF_EN`

## Operation
- Load-use hazard is asserted when all of the following hold: `id_valid`, `ex_valid`, `ex_MemRead`, `ex_rd != 0`, and at least one of:
  - `ex_rd == id_rs1`, with rs1 used (every `ALUOp` value);
  - `ex_rd == id_rs2`, with rs2 used (`ALUOp` 10, `ALUOp` 01, or `id_MemWrite`=1).
- `id_stall = !flush && (load_use || ex_stall)`.
- Register update per clock edge. Priority: `reset` > `flush` > `ex_stall` > `load_use` > load.
  - `reset`: every `ex_*` output and `ex_valid` become 0.
  - `flush`: insert a bubble.
  - `ex_stall`: hold all fields.
  - `load_use`: insert a bubble.
  - otherwise: capture all `id_*` fields, and `ex_valid <= id_valid`.
- Bubble: `ex_valid`, every control bit, `ex_ALUOp`, `ex_Funct3`, `ex_Funct7`, data, indices and PC all become 0. With `ALUOp`=00 the ALU performs a harmless add.
- Capture with `id_valid`=0 also forces all controls to 0. No side-effecting control may leave the block with `ex_valid`=0.

## Timing
- Latency is 1 cycle from `id_*` to `ex_*`. All `ex_*` outputs are flops with no combinational path from inputs.
- `id_stall` is combinational from `id_*`, registered `ex_*`, `flush` and `ex_stall`. There is no path through the flops' D inputs.
- A load-use stall lasts exactly 1 cycle: the bubble clears `ex_MemRead`, so the held ID instruction then proceeds.
- `flush` together with `ex_stall`: `flush` wins, a bubble is inserted, and `id_stall`=0.
- `reset` mid-stall: all outputs are 0 the next cycle, and `id_stall` falls once the flops clear.

## Configuration
- `ID_EX_PERF_EN` defined: `bubble_count` increments by 1 on each cycle in which a bubble is inserted (flush or load_use, not reset). It saturates at 0xFFFFFFFF and clears on `reset`.
- `ID_EX_PERF_EN` undefined: the `bubble_count` port and counter are absent.

## Structure
- Shared package `riscv_pkg`:
  - `ALUOp` localparams `ALUOP_MEM`=2'b00, `ALUOP_BRANCH`=2'b01, `ALUOP_RTYPE`=2'b10, `ALUOP_ITYPE`=2'b11;
  - packed struct `ex_ctrl_t` for the six control bits plus `ALUOp`/`Funct3`/`Funct7`.
- One sub-module, `load_use_detect`: purely combinational, with inputs `id_*` indices, `id_ALUOp`, `id_MemWrite`, `id_valid`, `ex_valid`, `ex_MemRead`, `ex_rd`, and output `load_use`.

## Test plan
- Reset, then three ADDs with no hazard → `ex_*` mirrors `id_*` one cycle later, `id_stall`=0 throughout.
- `lw x5` in EX, `add x6,x5,x7` in ID → `id_stall`=1 for 1 cycle, a bubble is inserted (`ex_valid`=0, `ex_RegWrite`=0), and then the add is captured with `ex_ALUOp`=10.
- `lw x5` in EX, `addi x6,x0,5` with `id_rs2` field=5 → no stall, because rs2 is unused for `ALUOp` 11.
- `lw x0` in EX, `add x1,x0,x0` in ID → no stall, because `ex_rd`=0.
- `ex_stall`=1 for 3 cycles with a valid SUB (`Funct7`=0x20) captured → `ex_*` is held for 3 cycles and `id_stall`=1. Then `flush` and `ex_stall` are asserted together → bubble, `id_stall`=0.
- With `ID_EX_PERF_EN`: 2 load-use stalls plus 1 flush → `bubble_count`=3, and `reset` returns it to 0.
